kbd_ram_writer: RTL and testbench
=================================

Name: kbd_ram_writer

Overview:
Parametrised keystroke-to-block-RAM write controller. Turns each key_code strobe into a single-cycle BRAM write port transaction: write enable, address and data. Adds the following over the fixed 8-bit/64-entry write path:
- data and address width generics
- a configurable depth
- stop-when-full or wrap mode
- backspace erase
- a clear sweep that zero-fills the buffer

Sits between the keyboard decoder and the BRAM write port.

Parameters:
DATA_W, 8, key code and BRAM data width
ADDR_W, 6, BRAM address width
DEPTH, 64, usable entries; 2 <= DEPTH <= 2**ADDR_W
WRAP_MODE, 0, 0 = drop keys when full; 1 = overwrite oldest, pointer wraps
BKSP_CODE, 8'h66, key code treated as backspace (DATA_W wide)
CLR_CODE, 8'h76, key code treated as clear-all (DATA_W wide)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
key_ready  input  1  one-cycle strobe, key_code valid
key_code  input  DATA_W  decoded key
write_enable  output  1  BRAM write strobe, one cycle per write
address  output  ADDR_W  BRAM write address
write_data  output  DATA_W  BRAM write data
count  output  ADDR_W+1  entries currently held, 0..DEPTH
full  output  1  count == DEPTH (combinational from count register)
overflow  output  1  sticky: a key was dropped while full (WRAP_MODE=0 only)
busy  output  1  clear sweep in progress

Behaviour:
- Single clock, synchronous active-high reset. One clock after rst is sampled high:
  - write_enable, address, write_data, count, overflow and busy are 0
  - the internal write pointer wr_ptr is 0
  - the state is IDLE
- write_enable, address and write_data are registered. A write appears exactly 1 cycle after the key_ready cycle. write_enable is high for exactly one cycle per write.
- FSM states: IDLE and CLEAR.
- IDLE, key_ready=0: write_enable <= 0; nothing else changes.
- IDLE, key_ready=1, decode priority (full DATA_W compare) is CLR_CODE > BKSP_CODE > normal key.
- Normal key, count < DEPTH:
  - write wr_ptr with key_code
  - wr_ptr <= (wr_ptr == DEPTH-1) ? 0 : wr_ptr+1
  - count+1
- Normal key, count == DEPTH, WRAP_MODE=0: no write, pointer and count unchanged, overflow <= 1.
- Normal key, count == DEPTH, WRAP_MODE=1: write wr_ptr with key_code, advance with wrap, count stays DEPTH, overflow stays 0.
- Backspace, count > 0:
  - wr_ptr <= (wr_ptr == 0) ? DEPTH-1 : wr_ptr-1
  - write 0 at that new pointer in the same transaction
  - count-1
  - overflow unchanged
- Backspace, count == 0: ignored; no write, no state change.
- Clear: go to CLEAR and set busy <= 1. On the next cycle and the DEPTH-1 cycles after it, write 0 to addresses 0,1,...,DEPTH-1 with write_enable high every cycle, so there are DEPTH consecutive writes.
- On the write of address DEPTH-1:
  - return to IDLE
  - busy <= 0
  - wr_ptr <= 0, count <= 0, overflow <= 0
- In CLEAR, key_ready is ignored and the key is dropped without setting overflow. Upstream must observe busy.
- Reset during CLEAR aborts the sweep immediately. Reset values apply; partially cleared contents are left as-is.
- Address arithmetic is modulo DEPTH, not modulo 2**ADDR_W. address never exceeds DEPTH-1.
- count is ADDR_W+1 bits so DEPTH = 2**ADDR_W is representable.
- key_ready asserted on back-to-back cycles is legal in IDLE. Each strobe produces its own write on consecutive cycles.

Test Plan:
(All with DEPTH=4, ADDR_W=2, WRAP_MODE=0 unless stated.)
1. Reset, then key_ready pulses with 8'h1C, 8'h32, 8'h21 -> writes (addr,data) = (0,1C), (1,32), (2,21), each 1 cycle after its strobe. count=3, full=0.
2. Five normal keys back-to-back -> four writes at addresses 0..3. The 5th strobe produces no write_enable. count=4, full=1, overflow=1 and stays 1.
3. Same as 2 with WRAP_MODE=1 -> 5th key writes address 0. count stays 4, overflow=0, next write goes to address 1.
4. After keys 1C,32, send 8'h66 -> write (1,00), count=1. Send 8'h66 twice more -> write (0,00), then nothing. count=0.
5. With count=3 and overflow=1, send 8'h76 -> busy=1 and four writes of 00 at addresses 0,1,2,3 on consecutive cycles. A key strobe mid-sweep produces no extra write. Afterwards busy=0, count=0, overflow=0, and the next key writes address 0.
6. Assert rst during the 2nd clear write -> next cycle write_enable=0, busy=0, count=0. The next key writes address 0.

Source files
------------

// File: rtl/kbd_ram_writer_if.sv
// Keystroke-in / BRAM-write-out bundle between keyboard decoder, writer and RAM.
// master drives key strobes and observes writes; slave is the writer itself.
interface kbd_ram_writer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic              key_ready;
    logic [DATA_W-1:0] key_code;
    logic              write_enable;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;

    modport master (
        output key_ready, key_code,
        input  write_enable, address, write_data
    );

    modport slave (
        input  key_ready, key_code,
        output write_enable, address, write_data
    );
endinterface

// File: rtl/kbd_ram_writer.sv
// Keystroke to BRAM write controller: one registered write 1 cycle after each key strobe.
// No backpressure on keys; while busy (clear sweep) strobes are dropped silently.
module kbd_ram_writer #(
    parameter int              DATA_W    = 8,
    parameter int              ADDR_W    = 6,
    parameter int              DEPTH     = 64,
    parameter int              WRAP_MODE = 0,
    parameter logic [DATA_W-1:0] BKSP_CODE = 8'h66,
    parameter logic [DATA_W-1:0] CLR_CODE  = 8'h76
) (
    input  logic              clk,
    input  logic              rst,
    kbd_ram_writer_if.slave   bus,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] nxt_ptr;
    logic [ADDR_W-1:0] prv_ptr;

    // Pointer arithmetic wraps at DEPTH, which need not be a power of two.
    assign nxt_ptr = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
    assign prv_ptr = (wr_ptr == '0) ? LAST : wr_ptr - 1'b1;
    assign full    = (count == DEPTH_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            wr_ptr           <= '0;
            clr_ptr          <= '0;
            count            <= '0;
            overflow         <= 1'b0;
            busy             <= 1'b0;
            bus.write_enable <= 1'b0;
            bus.address      <= '0;
            bus.write_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.write_enable <= 1'b0;
                    if (bus.key_ready) begin
                        if (bus.key_code == CLR_CODE) begin
                            state   <= CLEAR;
                            busy    <= 1'b1;
                            clr_ptr <= '0;
                        end else if (bus.key_code == BKSP_CODE) begin
                            if (count != '0) begin
                                wr_ptr           <= prv_ptr;
                                bus.write_enable <= 1'b1;
                                bus.address      <= prv_ptr;
                                bus.write_data   <= '0;
                                count            <= count - 1'b1;
                            end
                        end else if (count != DEPTH_C) begin
                            wr_ptr           <= nxt_ptr;
                            bus.write_enable <= 1'b1;
                            bus.address      <= wr_ptr;
                            bus.write_data   <= bus.key_code;
                            count            <= count + 1'b1;
                        end else if (WRAP_MODE != 0) begin
                            // Full in wrap mode: overwrite the oldest entry, count saturates.
                            wr_ptr           <= nxt_ptr;
                            bus.write_enable <= 1'b1;
                            bus.address      <= wr_ptr;
                            bus.write_data   <= bus.key_code;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    bus.write_enable <= 1'b1;
                    bus.address      <= clr_ptr;
                    bus.write_data   <= '0;
                    if (clr_ptr == LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        wr_ptr   <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kbd_ram_writer.sv
// Bench for kbd_ram_writer: stop-when-full and wrap instances, scoreboarded BRAM writes.
module tb_kbd_ram_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    kbd_ram_writer_if #(.DATA_W(8), .ADDR_W(2)) b0 ();
    kbd_ram_writer_if #(.DATA_W(8), .ADDR_W(2)) b1 ();

    logic [2:0] cnt0, cnt1;
    logic       full0, full1, ovf0, ovf1, busy0, busy1;

    kbd_ram_writer #(.DATA_W(8), .ADDR_W(2), .DEPTH(4), .WRAP_MODE(0)) u0 (
        .clk(clk), .rst(rst), .bus(b0.slave),
        .count(cnt0), .full(full0), .overflow(ovf0), .busy(busy0)
    );

    kbd_ram_writer #(.DATA_W(8), .ADDR_W(2), .DEPTH(4), .WRAP_MODE(1)) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave),
        .count(cnt1), .full(full1), .overflow(ovf1), .busy(busy1)
    );

    typedef struct {
        logic [1:0] a;
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input string nm, input logic [1:0] a, input logic [7:0] d, inout exp_t q[$]);
        exp_t e;
        if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s unexpected write: addr %0h data %0h (cycle %0d)", nm, a, d, cyc);
        end else begin
            e = q.pop_front();
            chk({nm, " addr"}, int'(a), int'(e.a));
            chk({nm, " data"}, int'(d), int'(e.d));
            chk({nm, " cycle"}, cyc, e.c);
        end
    endtask

    always @(negedge clk) if (b0.write_enable === 1'b1) mon("u0", b0.address, b0.write_data, q0);
    always @(negedge clk) if (b1.write_enable === 1'b1) mon("u1", b1.address, b1.write_data, q1);

    // Expected write for a strobe issued now, visible dly cycles later.
    task automatic exp0(input logic [1:0] a, input logic [7:0] d, input int dly);
        q0.push_back('{a, d, cyc + dly});
    endtask

    task automatic exp1(input logic [1:0] a, input logic [7:0] d, input int dly);
        q1.push_back('{a, d, cyc + dly});
    endtask

    task automatic press0(input logic [7:0] c);
        b0.key_ready = 1'b1;
        b0.key_code  = c;
        @(negedge clk);
        b0.key_ready = 1'b0;
    endtask

    task automatic press1(input logic [7:0] c);
        b1.key_ready = 1'b1;
        b1.key_code  = c;
        @(negedge clk);
        b1.key_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        b0.key_ready = 1'b0; b0.key_code = '0;
        b1.key_ready = 1'b0; b1.key_code = '0;
        @(negedge clk);
        do_reset();

        chk("rst we", b0.write_enable, 0);
        chk("rst addr", b0.address, 0);
        chk("rst data", b0.write_data, 0);
        chk("rst count", cnt0, 0);
        chk("rst full", full0, 0);
        chk("rst overflow", ovf0, 0);
        chk("rst busy", busy0, 0);

        // Three spaced keys.
        exp0(2'd0, 8'h1C, 1); press0(8'h1C); @(negedge clk);
        exp0(2'd1, 8'h32, 1); press0(8'h32); @(negedge clk);
        exp0(2'd2, 8'h21, 1); press0(8'h21);
        chk("t1 count", cnt0, 3);
        chk("t1 full", full0, 0);

        // Wrap instance: five back-to-back keys overwrite address 0.
        exp1(2'd0, 8'h15, 1); press1(8'h15);
        exp1(2'd1, 8'h1D, 1); press1(8'h1D);
        exp1(2'd2, 8'h24, 1); press1(8'h24);
        exp1(2'd3, 8'h2D, 1); press1(8'h2D);
        exp1(2'd0, 8'h2C, 1); press1(8'h2C);
        chk("t3 count", cnt1, 4);
        chk("t3 full", full1, 1);
        chk("t3 overflow", ovf1, 0);
        @(negedge clk);
        exp1(2'd1, 8'h35, 1); press1(8'h35);
        chk("t3 count after", cnt1, 4);

        // Five back-to-back keys, stop-when-full.
        do_reset();
        exp0(2'd0, 8'h15, 1); press0(8'h15);
        exp0(2'd1, 8'h1D, 1); press0(8'h1D);
        exp0(2'd2, 8'h24, 1); press0(8'h24);
        exp0(2'd3, 8'h2D, 1); press0(8'h2D);
        press0(8'h2C);
        chk("t2 count", cnt0, 4);
        chk("t2 full", full0, 1);
        chk("t2 overflow", ovf0, 1);
        @(negedge clk); @(negedge clk);
        chk("t2 overflow sticky", ovf0, 1);

        // Backspace from full wraps pointer 0 -> 3 and keeps overflow.
        exp0(2'd3, 8'h00, 1); press0(8'h66);
        chk("t5 pre count", cnt0, 3);
        chk("t5 pre overflow", ovf0, 1);

        // Clear sweep with a key strobe in the middle of it.
        exp0(2'd0, 8'h00, 2);
        exp0(2'd1, 8'h00, 3);
        exp0(2'd2, 8'h00, 4);
        exp0(2'd3, 8'h00, 5);
        press0(8'h76);
        chk("t5 busy", busy0, 1);
        press0(8'h1C);
        repeat (4) @(negedge clk);
        chk("t5 busy after", busy0, 0);
        chk("t5 count after", cnt0, 0);
        chk("t5 overflow after", ovf0, 0);
        exp0(2'd0, 8'h43, 1); press0(8'h43);
        chk("t5 next count", cnt0, 1);

        // Backspace erase down to empty and past it.
        do_reset();
        exp0(2'd0, 8'h1C, 1); press0(8'h1C);
        exp0(2'd1, 8'h32, 1); press0(8'h32);
        exp0(2'd1, 8'h00, 1); press0(8'h66);
        chk("t4 count 1", cnt0, 1);
        exp0(2'd0, 8'h00, 1); press0(8'h66);
        press0(8'h66);
        chk("t4 count 0", cnt0, 0);
        chk("t4 overflow", ovf0, 0);

        // Reset aborts a clear sweep during its second write.
        @(negedge clk);
        exp0(2'd0, 8'h00, 2);
        exp0(2'd1, 8'h00, 3);
        press0(8'h76);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6 we", b0.write_enable, 0);
        chk("t6 busy", busy0, 0);
        chk("t6 count", cnt0, 0);
        rst = 1'b0;
        exp0(2'd0, 8'h5A, 1); press0(8'h5A);
        repeat (3) @(negedge clk);

        chk("u0 pending writes", q0.size(), 0);
        chk("u1 pending writes", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
